gf180mcu_ocd_io__pwrseq: RTL and testbench
==========================================

Name: gf180mcu_ocd_io__pwrseq

Overview:
- Parametrised supply sequencer for the pad-ring power domains (DVDD/VDD pairs served by the vdd/vss pad cells).
- Enables NRAIL rail switches in ascending order and disables them in descending order.
- Debounces each rail's analog power-good detector and flags brown-out or ramp timeout as a latched fault.
- Sits between the chip-level power controller and the per-domain rail switch/clamp enables in the IO ring.

Parameters:
- NRAIL, 4, number of supply domains sequenced (1..8).
- DB_CYC, 16, consecutive synchronized cycles for a PG transition to be accepted (>=1).
- SEQ_DLY, 1000, settle cycles after a rail's PG is accepted before the next rail is enabled or ALL_GOOD is asserted.
- TMO, 4096, maximum cycles from RAIL_EN[i] rising to debounced PG[i] high before a fault (> DB_CYC+2).
- CW, 16, width of the shared delay/timeout counter; must hold max(SEQ_DLY, TMO).

Ports:
- CLK, input, 1, sequencer clock.
- RST, input, 1, asynchronous active-high reset.
- EN_REQ, input, 1, level request: 1 = power up all domains, 0 = power down.
- PG, input, NRAIL, raw asynchronous power-good per rail from the pad-ring detectors.
- RAIL_EN, output, NRAIL, rail switch enable per domain.
- ALL_GOOD, output, 1, all rails enabled, debounced-good and settled.
- BUSY, output, 1, sequencing up or down in progress.
- FAULT, output, 1, latched fault indication.
- FAULT_RAIL, output, max(1,$clog2(NRAIL)), index of the first faulting rail.
- FAULT_TMO, output, 1, 1 = ramp timeout, 0 = PG drop (brown-out).

Behaviour:
- Reset (async on RST high): all outputs 0; FSM in OFF; synchronizers, debounce state and counters cleared. Applying RST mid-sequence drops all RAIL_EN in the same instant. No ordered power-down is performed on reset.
- PG path: 2-flop synchronizer per rail, then a per-rail debouncer.
  - pg_ok[i] toggles only after DB_CYC consecutive synced samples differing from its current value.
  - Latency from a raw PG edge to a pg_ok change is DB_CYC+2 cycles.
- FSM states: OFF, UP_WAIT, UP_SETTLE, ON, DN_SETTLE, FLT. Rail index idx runs 0..NRAIL-1.
- OFF:
  - If EN_REQ=1: idx=0, RAIL_EN[0]=1, counter cleared, go to UP_WAIT. BUSY=1 from the next cycle.
- UP_WAIT:
  - Counter increments each cycle.
  - When pg_ok[idx]=1: go to UP_SETTLE with the counter cleared.
  - When the counter reaches TMO-1 without pg_ok[idx]: go to FLT with FAULT_TMO=1 and FAULT_RAIL=idx.
- UP_SETTLE:
  - Waits SEQ_DLY cycles.
  - If idx<NRAIL-1: idx++, set RAIL_EN[idx], go to UP_WAIT.
  - Otherwise go to ON: ALL_GOOD=1, BUSY=0.
- ON:
  - If EN_REQ=0: ALL_GOOD=0, idx=NRAIL-1, clear RAIL_EN[idx], go to DN_SETTLE.
- DN_SETTLE:
  - Waits SEQ_DLY cycles.
  - If idx>0: idx--, clear RAIL_EN[idx], repeat.
  - When idx=0 completes: go to OFF.
  - Power-down does not wait for PG to fall.
- EN_REQ reversal:
  - EN_REQ falling during UP_WAIT/UP_SETTLE: abort and start descending power-down from the highest enabled rail.
  - EN_REQ rising during DN_SETTLE: finish the full power-down to OFF first, then restart from OFF.
- Brown-out: in UP_WAIT, UP_SETTLE or ON, pg_ok falling on any enabled rail whose PG was already accepted causes:
  - all RAIL_EN cleared simultaneously (no ordering), ALL_GOOD=0;
  - FLT entered with FAULT_TMO=0 and FAULT_RAIL set to the lowest such rail index (simultaneous drops resolve to the lowest).
- FLT: FAULT=1, RAIL_EN=0, BUSY=0. Exit to OFF only when EN_REQ=0 and all pg_ok=0. FAULT, FAULT_RAIL and FAULT_TMO clear on exit.
- Outputs are registered: no combinational path from any input to any output.
- The counter saturates and never wraps.

Decomposition:
- Package gf180mcu_ocd_io__pwrseq_pkg: FSM state enum; FAULT_RAIL width function; default constants for DB_CYC, SEQ_DLY and TMO.
- One sub-module, gf180mcu_ocd_io__pgdeb:
  - handles one rail: 2-flop sync plus DB_CYC debounce counter;
  - ports CLK, RST, PG, PG_OK; parameter DB_CYC;
  - instantiated NRAIL times in a generate loop.

Test Plan:
- Test parameters for all scenarios: NRAIL=3, DB_CYC=4, SEQ_DLY=10, TMO=50.
- Power-up: EN_REQ=1; PG[i] driven high 5 cycles after RAIL_EN[i] rises.
  - RAIL_EN[i] rises spaced 5+6+10=21 cycles apart.
  - ALL_GOOD rises 6+10 cycles after PG[2]; BUSY is 0 in the ON state.
- Power-down: from ON, EN_REQ=0.
  - ALL_GOOD falls next cycle.
  - RAIL_EN clears in order 2, 1, 0 at 10-cycle spacing; state returns to OFF.
- Timeout: PG[1] held low.
  - 50 cycles after RAIL_EN[1] rises: FAULT=1, FAULT_TMO=0b1, FAULT_RAIL=1, RAIL_EN=000.
- Brown-out and glitch filtering in ON:
  - a 3-cycle low glitch on PG[2] causes no change;
  - a 6-cycle low on PG[2] gives FAULT=1, FAULT_TMO=0, FAULT_RAIL=2, RAIL_EN=000;
  - fault clears only after EN_REQ=0 and all PG are low.
- Async reset mid-UP_SETTLE of rail 1: RST pulsed between clock edges → RAIL_EN=000 and BUSY=0 immediately, before the next CLK edge.
- Abort: EN_REQ drops during rail 1 UP_WAIT → RAIL_EN[1] clears first, RAIL_EN[0] clears 10 cycles later; no FAULT is raised.

Source files
------------

// File: rtl/gf180mcu_ocd_io__pwrseq_pkg.sv
// Purpose: shared types and defaults for the pad-ring supply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gf180mcu_ocd_io__pwrseq_pkg;

    typedef enum logic [2:0] {
        S_OFF,
        S_UP_WAIT,
        S_UP_SETTLE,
        S_ON,
        S_DN_SETTLE,
        S_FLT
    } state_t;

    localparam int DB_CYC_DEF  = 16;
    localparam int SEQ_DLY_DEF = 1000;
    localparam int TMO_DEF     = 4096;

    // Width of a rail index; a single rail still needs one bit.
    function automatic int rail_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__pgdeb.sv
// Purpose: synchronize one raw power-good line and debounce it over DB_CYC samples.
// Latency: DB_CYC+2 cycles from a raw PG edge to a PG_OK change.
// Backpressure: none; free-running level filter.
module gf180mcu_ocd_io__pgdeb #(
    parameter int DB_CYC = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic PG,
    output logic PG_OK
);

    localparam int              DW   = $clog2(DB_CYC + 1);
    localparam logic [DW-1:0]   LAST = DW'(DB_CYC - 1);

    logic          s1;
    logic          s2;
    logic [DW-1:0] cnt;

    // Two-flop sync, then count consecutive samples that disagree with PG_OK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            PG_OK <= 1'b0;
        end else begin
            s1 <= PG;
            s2 <= s1;
            if (s2 != PG_OK) begin
                if (cnt == LAST) begin
                    PG_OK <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_ocd_io__pwrseq.sv
// Purpose: ordered power-up/down of NRAIL pad-ring supply domains with brown-out/timeout fault latch.
// Latency: all outputs registered; one cycle from a sampled input to an output change.
// Backpressure: none; EN_REQ is a level request, reversals are absorbed by the FSM.
module gf180mcu_ocd_io__pwrseq
    import gf180mcu_ocd_io__pwrseq_pkg::*;
#(
    parameter int NRAIL   = 4,
    parameter int DB_CYC  = DB_CYC_DEF,
    parameter int SEQ_DLY = SEQ_DLY_DEF,
    parameter int TMO     = TMO_DEF,
    parameter int CW      = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN_REQ,
    input  logic [NRAIL-1:0]          PG,
    output logic [NRAIL-1:0]          RAIL_EN,
    output logic                      ALL_GOOD,
    output logic                      BUSY,
    output logic                      FAULT,
    output logic [rail_w(NRAIL)-1:0]  FAULT_RAIL,
    output logic                      FAULT_TMO
);

    localparam int            RW      = rail_w(NRAIL);
    localparam logic [RW-1:0] LAST    = RW'(NRAIL - 1);
    localparam logic [CW-1:0] TMO_END = CW'(TMO - 1);
    localparam logic [CW-1:0] DN_END  = CW'(SEQ_DLY - 1);
    // Up-settle is measured from the cycle pg_ok rose, one cycle before the FSM sees it.
    localparam logic [CW-1:0] UPS_END = CW'((SEQ_DLY >= 2) ? (SEQ_DLY - 2) : 0);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [RW-1:0]     idx;
    logic [RW-1:0]     idx_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     cnt_inc;
    logic [NRAIL-1:0]  pg_ok;
    logic [NRAIL-1:0]  acc;
    logic [NRAIL-1:0]  drop;
    logic [RW-1:0]     drop_idx;
    logic [NRAIL-1:0]  rail_en_nxt;
    logic [RW-1:0]     fr_nxt;
    logic              ft_nxt;

    for (genvar g = 0; g < NRAIL; g++) begin : g_deb
        gf180mcu_ocd_io__pgdeb #(.DB_CYC(DB_CYC)) u_deb (
            .CLK   (CLK),
            .RST   (RST),
            .PG    (PG[g]),
            .PG_OK (pg_ok[g])
        );
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Rails whose PG has been accepted, those that dropped, and the lowest dropped index.
    always_comb begin
        acc      = '0;
        drop     = '0;
        drop_idx = '0;
        for (int i = 0; i < NRAIL; i++) begin
            acc[i] = (state == S_ON)
                   | ((state == S_UP_WAIT)   && (i <  int'(idx)))
                   | ((state == S_UP_SETTLE) && (i <= int'(idx)));
        end
        drop = acc & ~pg_ok;
        for (int i = NRAIL - 1; i >= 0; i--) begin
            if (drop[i]) drop_idx = RW'(i);
        end
    end

    // Next state, rail index, counter and rail enables.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt_inc;
        rail_en_nxt = RAIL_EN;
        fr_nxt      = FAULT_RAIL;
        ft_nxt      = FAULT_TMO;
        case (state)
            S_OFF: begin
                cnt_nxt = '0;
                if (EN_REQ) begin
                    idx_nxt        = '0;
                    rail_en_nxt    = '0;
                    rail_en_nxt[0] = 1'b1;
                    state_nxt      = S_UP_WAIT;
                end
            end
            S_UP_WAIT, S_UP_SETTLE, S_ON: begin
                if (|drop) begin
                    state_nxt   = S_FLT;
                    rail_en_nxt = '0;
                    fr_nxt      = drop_idx;
                    ft_nxt      = 1'b0;
                    cnt_nxt     = '0;
                end else if (!EN_REQ) begin
                    // idx is always the highest enabled rail here.
                    state_nxt        = S_DN_SETTLE;
                    rail_en_nxt[idx] = 1'b0;
                    cnt_nxt          = '0;
                end else begin
                    case (state)
                        S_UP_WAIT: begin
                            if (pg_ok[idx]) begin
                                state_nxt = S_UP_SETTLE;
                                cnt_nxt   = '0;
                            end else if (cnt == TMO_END) begin
                                state_nxt   = S_FLT;
                                rail_en_nxt = '0;
                                fr_nxt      = idx;
                                ft_nxt      = 1'b1;
                                cnt_nxt     = '0;
                            end
                        end
                        S_UP_SETTLE: begin
                            if (cnt >= UPS_END) begin
                                cnt_nxt = '0;
                                if (idx != LAST) begin
                                    idx_nxt              = idx + 1'b1;
                                    rail_en_nxt[idx_nxt] = 1'b1;
                                    state_nxt            = S_UP_WAIT;
                                end else begin
                                    state_nxt = S_ON;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_DN_SETTLE: begin
                // Ordered shutdown runs to completion regardless of EN_REQ or PG.
                if (cnt >= DN_END) begin
                    cnt_nxt = '0;
                    if (idx != '0) begin
                        idx_nxt              = idx - 1'b1;
                        rail_en_nxt[idx_nxt] = 1'b0;
                    end else begin
                        state_nxt = S_OFF;
                    end
                end
            end
            S_FLT: begin
                rail_en_nxt = '0;
                cnt_nxt     = '0;
                if (!EN_REQ && (pg_ok == '0)) begin
                    state_nxt = S_OFF;
                    fr_nxt    = '0;
                    ft_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt   = S_OFF;
                rail_en_nxt = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops every rail at once.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_OFF;
            idx        <= '0;
            cnt        <= '0;
            RAIL_EN    <= '0;
            ALL_GOOD   <= 1'b0;
            BUSY       <= 1'b0;
            FAULT      <= 1'b0;
            FAULT_RAIL <= '0;
            FAULT_TMO  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            RAIL_EN    <= rail_en_nxt;
            ALL_GOOD   <= (state_nxt == S_ON);
            BUSY       <= (state_nxt == S_UP_WAIT) || (state_nxt == S_UP_SETTLE) ||
                          (state_nxt == S_DN_SETTLE);
            FAULT      <= (state_nxt == S_FLT);
            FAULT_RAIL <= fr_nxt;
            FAULT_TMO  <= ft_nxt;
        end
    end

endmodule

// File: tb/tb_gf180mcu_ocd_io__pwrseq.sv
// Purpose: directed bench for the supply sequencer (NRAIL=3, DB_CYC=4, SEQ_DLY=10, TMO=50).
// Latency: checks sampled 1 time unit after each rising CLK edge.
// Backpressure: n/a.
module tb_gf180mcu_ocd_io__pwrseq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       EN_REQ = 1'b0;
    logic [2:0] PG = 3'b000;
    logic [2:0] RAIL_EN;
    logic       ALL_GOOD;
    logic       BUSY;
    logic       FAULT;
    logic [1:0] FAULT_RAIL;
    logic       FAULT_TMO;

    int checks = 0;
    int errors = 0;

    gf180mcu_ocd_io__pwrseq #(
        .NRAIL(3), .DB_CYC(4), .SEQ_DLY(10), .TMO(50), .CW(16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN_REQ     (EN_REQ),
        .PG         (PG),
        .RAIL_EN    (RAIL_EN),
        .ALL_GOOD   (ALL_GOOD),
        .BUSY       (BUSY),
        .FAULT      (FAULT),
        .FAULT_RAIL (FAULT_RAIL),
        .FAULT_TMO  (FAULT_TMO)
    );

    always #5 CLK = ~CLK;

    // At cycle cyc: check expected outputs first, then drive en/pg for later edges.
    typedef struct {
        int         cyc;
        logic       en;
        logic [2:0] pg;
        logic [2:0] rail;
        logic       ag;
        logic       busy;
        logic       flt;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [2:0] rail, input logic ag,
                           input logic busy, input logic flt);
        chk(name, {26'd0, RAIL_EN, ALL_GOOD, BUSY, FAULT}, {26'd0, rail, ag, busy, flt});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST    = 1'b1;
        EN_REQ = 1'b0;
        PG     = 3'b000;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        tick(1);
    endtask

    // Full power-up; each PG rises 5 cycles after its rail, ends on the ALL_GOOD cycle.
    task automatic power_up();
        EN_REQ = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            tick(5);
            PG[i] = 1'b1;
            tick(16);
        end
    endtask

    function automatic void add(input int c, input logic e, input logic [2:0] p,
                                input logic [2:0] r, input logic a, input logic b,
                                input logic f);
        vec_t v;
        v.cyc = c; v.en = e; v.pg = p; v.rail = r; v.ag = a; v.busy = b; v.flt = f;
        vt.push_back(v);
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int cur;

        // cycle  en  pg      rail    ag    busy  fault
        add(0,   1, 3'b000, 3'b000, 0, 0, 0);
        add(1,   1, 3'b000, 3'b001, 0, 1, 0);
        add(6,   1, 3'b001, 3'b001, 0, 1, 0);
        add(21,  1, 3'b001, 3'b001, 0, 1, 0);
        add(22,  1, 3'b001, 3'b011, 0, 1, 0);
        add(27,  1, 3'b011, 3'b011, 0, 1, 0);
        add(42,  1, 3'b011, 3'b011, 0, 1, 0);
        add(43,  1, 3'b011, 3'b111, 0, 1, 0);
        add(48,  1, 3'b111, 3'b111, 0, 1, 0);
        add(63,  1, 3'b111, 3'b111, 0, 1, 0);
        add(64,  1, 3'b111, 3'b111, 1, 0, 0);
        add(70,  0, 3'b111, 3'b111, 1, 0, 0);
        add(71,  0, 3'b111, 3'b011, 0, 1, 0);
        add(80,  0, 3'b111, 3'b011, 0, 1, 0);
        add(81,  0, 3'b111, 3'b001, 0, 1, 0);
        add(90,  0, 3'b111, 3'b001, 0, 1, 0);
        add(91,  0, 3'b111, 3'b000, 0, 1, 0);
        add(100, 0, 3'b111, 3'b000, 0, 1, 0);
        add(101, 0, 3'b000, 3'b000, 0, 0, 0);

        // Power-up / power-down timed table.
        do_reset();
        chk("reset_fault_rail", {30'd0, FAULT_RAIL}, 32'd0);
        chk("reset_fault_tmo", {31'd0, FAULT_TMO}, 32'd0);
        cur = 0;
        foreach (vt[k]) begin
            tick(vt[k].cyc - cur);
            cur = vt[k].cyc;
            chk($sformatf("vec%0d_c%0d", k, vt[k].cyc), {29'd0, RAIL_EN, ALL_GOOD, BUSY, FAULT},
                {29'd0, vt[k].rail, vt[k].ag, vt[k].busy, vt[k].flt});
            EN_REQ = vt[k].en;
            PG     = vt[k].pg;
        end

        // Ramp timeout on rail 1.
        do_reset();
        EN_REQ = 1'b1;
        tick(1);
        tick(5);
        PG = 3'b001;
        tick(16);
        chk_out("tmo_rail1_on", 3'b011, 0, 1, 0);
        tick(49);
        chk_out("tmo_before", 3'b011, 0, 1, 0);
        tick(1);
        chk_out("tmo_fault", 3'b000, 0, 0, 1);
        chk("tmo_flag", {31'd0, FAULT_TMO}, 32'd1);
        chk("tmo_rail", {30'd0, FAULT_RAIL}, 32'd1);
        EN_REQ = 1'b0;
        tick(10);
        chk_out("tmo_hold_pg_high", 3'b000, 0, 0, 1);
        PG = 3'b000;
        tick(6);
        chk_out("tmo_hold_deb", 3'b000, 0, 0, 1);
        tick(1);
        chk_out("tmo_cleared", 3'b000, 0, 0, 0);
        chk("tmo_flag_clr", {31'd0, FAULT_TMO}, 32'd0);
        chk("tmo_rail_clr", {30'd0, FAULT_RAIL}, 32'd0);

        // Glitch filter then brown-out on rail 2.
        do_reset();
        power_up();
        chk_out("bo_on", 3'b111, 1, 0, 0);
        PG[2] = 1'b0;
        tick(3);
        PG[2] = 1'b1;
        tick(20);
        chk_out("bo_glitch_ignored", 3'b111, 1, 0, 0);
        PG[2] = 1'b0;
        tick(6);
        chk_out("bo_before", 3'b111, 1, 0, 0);
        PG[2] = 1'b1;
        tick(1);
        chk_out("bo_fault", 3'b000, 0, 0, 1);
        chk("bo_flag", {31'd0, FAULT_TMO}, 32'd0);
        chk("bo_rail", {30'd0, FAULT_RAIL}, 32'd2);
        tick(10);
        chk_out("bo_hold_en_high", 3'b000, 0, 0, 1);
        EN_REQ = 1'b0;
        tick(10);
        chk_out("bo_hold_pg_high", 3'b000, 0, 0, 1);
        PG = 3'b000;
        tick(6);
        chk_out("bo_hold_deb", 3'b000, 0, 0, 1);
        tick(1);
        chk_out("bo_cleared", 3'b000, 0, 0, 0);

        // Simultaneous drop of rails 1 and 2 reports the lower index.
        do_reset();
        power_up();
        PG = 3'b001;
        tick(7);
        chk_out("bo2_fault", 3'b000, 0, 0, 1);
        chk("bo2_rail", {30'd0, FAULT_RAIL}, 32'd1);

        // Async reset in rail 1 UP_SETTLE.
        do_reset();
        EN_REQ = 1'b1;
        tick(1);
        tick(5);
        PG = 3'b001;
        tick(16);
        tick(5);
        PG = 3'b011;
        tick(8);
        chk_out("rst_in_settle", 3'b011, 0, 1, 0);
        #2;
        RST = 1'b1;
        #1;
        chk_out("rst_async", 3'b000, 0, 0, 0);
        EN_REQ = 1'b0;
        PG     = 3'b000;
        #3;
        RST = 1'b0;
        tick(1);
        chk_out("rst_after", 3'b000, 0, 0, 0);

        // Abort during rail 1 UP_WAIT.
        do_reset();
        EN_REQ = 1'b1;
        tick(1);
        tick(5);
        PG = 3'b001;
        tick(16);
        tick(3);
        chk_out("abort_wait", 3'b011, 0, 1, 0);
        EN_REQ = 1'b0;
        tick(1);
        chk_out("abort_rail1_off", 3'b001, 0, 1, 0);
        tick(9);
        chk_out("abort_rail0_hold", 3'b001, 0, 1, 0);
        tick(1);
        chk_out("abort_rail0_off", 3'b000, 0, 1, 0);
        tick(10);
        chk_out("abort_off", 3'b000, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
